frog_controller: RTL and testbench

Consumes the one-pulse-per-press direction strobes produced by the per-key input conditioners and turns them into the frog's grid position, score and round state. Sits between the four conditioned direction keys and the display/collision logic of the 16x16 LED playfield. Owns hop legality, boundary clamping, death/goal freeze periods and respawn.

---
 rtl/frog_controller.sv | 165 ++++++++++++++++
 tb/tb_frog_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/frog_controller.sv
// frog_controller
//   Turns one-cycle direction strobes into the frog's grid position, score and
//   round state for the 16x16 LED playfield. Owns hop legality, edge clamping,
//   the death/goal freeze periods and respawn at (START_COL, 0).
//
//   State | meaning
//   PLAY  | frog accepts moves, hazards kill
//   DEAD  | hit taken, frog hidden, freeze running
//   GOAL  | goal row reached, frog shown, freeze running
//   OVER  | lives exhausted, frozen until reset (FROG_LIVES_EN only)
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   up/down/left/right: one-cycle move strobes, priority up>down>left>right
//   hit               : frog overlaps a hazard this cycle
//   frog_x, frog_y    : current cell
//   frog_vis          : frog drawn when 1
//   hop               : one-cycle pulse on every accepted move
//   score             : goals reached, saturating at 255
//   lives, game_over  : present only when FROG_LIVES_EN is defined
//
// Config macro: FROG_LIVES_EN enables the three-life game with a terminal state.
module frog_controller #(
  parameter int COLS          = 16,
  parameter int ROWS          = 16,
  parameter int START_COL     = 7,
  parameter int FREEZE_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       hit,
  output logic [3:0] frog_x,
  output logic [3:0] frog_y,
  output logic       frog_vis,
  output logic       hop,
  output logic [7:0] score
`ifdef FROG_LIVES_EN
  ,
  output logic [1:0] lives,
  output logic       game_over
`endif
);

  localparam int CW = $clog2(FREEZE_CYCLES);
  localparam logic [CW-1:0] FREEZE_LOAD = CW'(FREEZE_CYCLES - 1);
  localparam logic [3:0] X_START = 4'(START_COL);
  localparam logic [3:0] X_MAX   = 4'(COLS - 1);
  // An up from this row lands on the goal row.
  localparam logic [3:0] Y_PRE_GOAL = 4'(ROWS - 2);

  typedef enum logic [1:0] {
    S_PLAY,
    S_DEAD,
    S_GOAL
`ifdef FROG_LIVES_EN
    , S_OVER
`endif
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_x;
  logic [3:0]    r_y;
  logic          r_vis;
  logic          r_hop;
  logic [7:0]    r_score;
`ifdef FROG_LIVES_EN
  logic [1:0]    r_lives;
  logic          r_game_over;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_PLAY;
      r_cnt   <= '0;
      r_x     <= X_START;
      r_y     <= 4'd0;
      r_vis   <= 1'b1;
      r_hop   <= 1'b0;
      r_score <= 8'd0;
`ifdef FROG_LIVES_EN
      r_lives     <= 2'd3;
      r_game_over <= 1'b0;
`endif
    end else begin
      r_hop <= 1'b0;
      case (r_state)
        S_PLAY: begin
          if (hit) begin
`ifdef FROG_LIVES_EN
            if (r_lives == 2'd1) begin
              // Last life: straight to the terminal state, no freeze.
              r_lives     <= 2'd0;
              r_game_over <= 1'b1;
              r_vis       <= 1'b0;
              r_state     <= S_OVER;
            end else begin
              r_lives <= r_lives - 2'd1;
              r_vis   <= 1'b0;
              r_cnt   <= FREEZE_LOAD;
              r_state <= S_DEAD;
            end
`else
            r_vis   <= 1'b0;
            r_cnt   <= FREEZE_LOAD;
            r_state <= S_DEAD;
`endif
          end else if (up) begin
            r_y   <= r_y + 4'd1;
            r_hop <= 1'b1;
            if (r_y == Y_PRE_GOAL) begin
              if (r_score != 8'hFF) r_score <= r_score + 8'd1;
              r_cnt   <= FREEZE_LOAD;
              r_state <= S_GOAL;
            end
          end else if (down) begin
            // A blocked strobe still wins priority; lower strobes are dropped.
            if (r_y != 4'd0) begin
              r_y   <= r_y - 4'd1;
              r_hop <= 1'b1;
            end
          end else if (left) begin
            if (r_x != 4'd0) begin
              r_x   <= r_x - 4'd1;
              r_hop <= 1'b1;
            end
          end else if (right) begin
            if (r_x != X_MAX) begin
              r_x   <= r_x + 4'd1;
              r_hop <= 1'b1;
            end
          end
        end
        S_DEAD, S_GOAL: begin
          if (r_cnt == '0) begin
            r_x     <= X_START;
            r_y     <= 4'd0;
            r_vis   <= 1'b1;
            r_state <= S_PLAY;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          // OVER (or an unused encoding): hold until reset.
        end
      endcase
    end
  end

  assign frog_x   = r_x;
  assign frog_y   = r_y;
  assign frog_vis = r_vis;
  assign hop      = r_hop;
  assign score    = r_score;
`ifdef FROG_LIVES_EN
  assign lives     = r_lives;
  assign game_over = r_game_over;
`endif

endmodule

// File: tb/tb_frog_controller.sv
// Self-checking bench for frog_controller with a short freeze (4 cycles).
// A behavioural model tracks position/score/freeze from the game rules and a
// negedge process compares every output each cycle; directed sections pin the
// model with literal values, then a randomized phase exercises mixed traffic.
module tb_frog_controller;
  localparam int F = 4;
`ifdef FROG_LIVES_EN
  localparam bit LIVES_EN = 1'b1;
`else
  localparam bit LIVES_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, hit = 1'b0;
  logic [3:0] frog_x, frog_y;
  logic       frog_vis, hop;
  logic [7:0] score;
`ifdef FROG_LIVES_EN
  logic [1:0] lives;
  logic       game_over;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  frog_controller #(
    .COLS(16), .ROWS(16), .START_COL(7), .FREEZE_CYCLES(F)
  ) dut (
    .clk(clk), .reset(reset),
    .up(up), .down(down), .left(left), .right(right), .hit(hit),
    .frog_x(frog_x), .frog_y(frog_y), .frog_vis(frog_vis), .hop(hop),
    .score(score)
`ifdef FROG_LIVES_EN
    , .lives(lives), .game_over(game_over)
`endif
  );

  // Behavioural model: freeze_left counts edges until respawn (0 = not frozen).
  int m_x, m_y, m_score, m_lives, freeze_left;
  bit m_vis, m_hop, m_over;

  always @(posedge clk) begin
    if (reset) begin
      m_x = 7; m_y = 0; m_score = 0; m_vis = 1; m_hop = 0;
      m_lives = 3; m_over = 0; freeze_left = 0;
    end else begin
      m_hop = 0;
      if (m_over) begin
      end else if (freeze_left > 0) begin
        freeze_left = freeze_left - 1;
        if (freeze_left == 0) begin
          m_x = 7; m_y = 0; m_vis = 1;
        end
      end else if (hit) begin
        if (LIVES_EN && m_lives == 1) begin
          m_lives = 0; m_over = 1; m_vis = 0;
        end else begin
          if (LIVES_EN) m_lives = m_lives - 1;
          m_vis = 0; freeze_left = F;
        end
      end else if (up) begin
        m_y = m_y + 1; m_hop = 1;
        if (m_y == 15) begin
          m_score = (m_score < 255) ? m_score + 1 : 255;
          freeze_left = F;
        end
      end else if (down) begin
        if (m_y > 0) begin m_y = m_y - 1; m_hop = 1; end
      end else if (left) begin
        if (m_x > 0) begin m_x = m_x - 1; m_hop = 1; end
      end else if (right) begin
        if (m_x < 15) begin m_x = m_x + 1; m_hop = 1; end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("frog_x", int'(frog_x), m_x);
    check("frog_y", int'(frog_y), m_y);
    check("frog_vis", int'(frog_vis), int'(m_vis));
    check("hop", int'(hop), int'(m_hop));
    check("score", int'(score), m_score);
`ifdef FROG_LIVES_EN
    check("lives", int'(lives), m_lives);
    check("game_over", int'(game_over), int'(m_over));
`endif
  end

  // v = {reset, hit, up, down, left, right}, applied at the next negedge.
  task automatic drive(input logic [5:0] v);
    @(negedge clk);
    {reset, hit, up, down, left, right} = v;
  endtask

  localparam logic [5:0] IDLE = 6'b000000;
  localparam logic [5:0] RST  = 6'b100000;
  localparam logic [5:0] HIT  = 6'b010000;
  localparam logic [5:0] UP   = 6'b001000;
  localparam logic [5:0] DN   = 6'b000100;
  localparam logic [5:0] LF   = 6'b000010;
  localparam logic [5:0] RT   = 6'b000001;

  initial begin
    drive(RST); drive(RST); drive(IDLE);
    check("rst_x", int'(frog_x), 7);
    check("rst_y", int'(frog_y), 0);
    check("rst_vis", int'(frog_vis), 1);
    check("rst_score", int'(score), 0);

    // three separate ups
    drive(UP); drive(IDLE); drive(UP); drive(IDLE); drive(UP); drive(IDLE);
    check("up3_y", int'(frog_y), 3);
    check("up3_x", int'(frog_x), 7);

    // down at row 0 and left at column 0 are ignored
    drive(RST); drive(DN); drive(IDLE);
    check("down_edge_y", int'(frog_y), 0);
    check("down_edge_hop", int'(hop), 0);
    for (int i = 0; i < 7; i++) drive(LF);
    drive(LF); drive(IDLE);
    check("left_edge_x", int'(frog_x), 0);
    check("left_edge_hop", int'(hop), 0);

    // up wins over right
    drive(RST); drive(UP | RT); drive(IDLE);
    check("prio_x", int'(frog_x), 7);
    check("prio_y", int'(frog_y), 1);

    // death freeze with strobes held
    drive(RST);
    for (int i = 0; i < 5; i++) drive(UP);
    drive(HIT | UP);
    for (int i = 0; i < F; i++) begin
      drive(UP);
      check("dead_vis", int'(frog_vis), 0);
    end
    drive(IDLE);
    check("respawn_x", int'(frog_x), 7);
    check("respawn_y", int'(frog_y), 0);
    check("respawn_vis", int'(frog_vis), 1);
    drive(UP); drive(IDLE);
    check("after_respawn_y", int'(frog_y), 1);

    // goal
    drive(RST);
    for (int i = 0; i < 15; i++) drive(UP);
    drive(IDLE);
    check("goal_score", int'(score), 1);
    check("goal_y", int'(frog_y), 15);
    check("goal_vis", int'(frog_vis), 1);
    for (int i = 0; i < F; i++) drive(IDLE);
    check("goal_respawn_x", int'(frog_x), 7);
    check("goal_respawn_y", int'(frog_y), 0);

    // score saturation
    for (int g = 0; g < 260; g++) begin
      for (int i = 0; i < 15; i++) drive(UP);
      for (int i = 0; i < F + 1; i++) drive(IDLE);
    end
    check("score_sat", int'(score), 255);

`ifdef FROG_LIVES_EN
    drive(RST); drive(HIT); drive(IDLE);
    check("lives_2", int'(lives), 2);
    for (int i = 0; i < F; i++) drive(IDLE);
    drive(HIT); drive(IDLE);
    check("lives_1", int'(lives), 1);
    for (int i = 0; i < F; i++) drive(IDLE);
    drive(HIT); drive(IDLE);
    check("lives_0", int'(lives), 0);
    check("game_over_set", int'(game_over), 1);
    check("over_vis", int'(frog_vis), 0);
    for (int i = 0; i < 8; i++) drive(UP);
    drive(IDLE);
    check("over_hold_y", int'(frog_y), 0);
    drive(RST); drive(IDLE);
    check("lives_rst", int'(lives), 3);
    check("game_over_rst", int'(game_over), 0);
`endif

    // randomized traffic
    drive(RST);
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] v;
      v[5] = ($urandom_range(0, 199) == 0);
      v[4] = ($urandom_range(0, 99) < 3);
      v[3] = ($urandom_range(0, 99) < 35);
      v[2] = ($urandom_range(0, 99) < 10);
      v[1] = ($urandom_range(0, 99) < 20);
      v[0] = ($urandom_range(0, 99) < 20);
      drive(v);
    end
    drive(IDLE); drive(IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
